// File: rtl/if_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the PC and a debug-loadable, word-addressed instruction memory.
// Produces PC+4 and the current instruction combinationally for IF/ID.
// A fetched HALT word freezes the PC until the next reset.

module if_stage #(
    parameter int              NB         = 32,
    parameter int              MEM_DEPTH  = 256,
    parameter int              ADDR_W     = 8,
    parameter logic [NB-1:0]   HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic              i_pc_write,
    input  logic              i_branch,
    input  logic [NB-1:0]     i_branch_addr,
    input  logic              i_jump,
    input  logic [NB-1:0]     i_jump_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [NB-1:0]     i_wr_data,
    output logic [NB-1:0]     o_pc,
    output logic [NB-1:0]     o_pc4,
    output logic [NB-1:0]     o_instruction,
    output logic              o_halt
);

    // Redirect targets are word aligned, so the two low bits are always cleared.
    localparam logic [NB-1:0] ALIGN_MASK = ~NB'(3);
    localparam logic [NB-1:0] PC_INCR    = NB'(4);

    logic [NB-1:0]     mem [MEM_DEPTH];
    logic [NB-1:0]     pc_q, pc_d;
    logic              halt_q, halt_d;
    logic [NB-1:0]     pc4;
    logic [NB-1:0]     fetch_word;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_in_range;
    logic              advance;

    // Zero-latency fetch: addresses past the end of memory read as HALT.
    always_comb begin
        pc4            = pc_q + PC_INCR;
        fetch_idx      = pc_q[ADDR_W+1:2];
        fetch_in_range = (pc_q[NB-1:ADDR_W+2] == '0);
        fetch_word     = fetch_in_range ? mem[fetch_idx] : HALT_INSTR;
    end

    // Next-PC selection: jump beats branch beats PC+4; a HALT fetch freezes instead.
    always_comb begin
        pc_d    = pc_q;
        halt_d  = halt_q;
        advance = i_step && i_pc_write && !halt_q;
        if (advance) begin
            if (fetch_word == HALT_INSTR) begin
                halt_d = 1'b1;
            end else if (i_jump) begin
                pc_d = i_jump_addr & ALIGN_MASK;
            end else if (i_branch) begin
                pc_d = i_branch_addr & ALIGN_MASK;
            end else begin
                pc_d = pc4;
            end
        end
    end

    // PC and sticky halt flag, cleared asynchronously by reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
        end
    end

    // Program load port; the memory is never cleared so a program survives reset.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc4         = pc4;
    assign o_instruction = fetch_word;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a behavioural fetch model kept here.

module tb_if_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_step;
    logic        i_pc_write;
    logic        i_branch;
    logic [31:0] i_branch_addr;
    logic        i_jump;
    logic [31:0] i_jump_addr;
    logic        i_wr_en;
    logic [7:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic [31:0] o_instruction;
    logic        o_halt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: program memory image, PC and halt flag.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;
    logic        m_halt;

    if_stage dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_step        (i_step),
        .i_pc_write    (i_pc_write),
        .i_branch      (i_branch),
        .i_branch_addr (i_branch_addr),
        .i_jump        (i_jump),
        .i_jump_addr   (i_jump_addr),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_pc          (o_pc),
        .o_pc4         (o_pc4),
        .o_instruction (o_instruction),
        .o_halt        (o_halt)
    );

    // Free-running 10 ns clock.
    always #5 i_clk = ~i_clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory is 256 words; anything beyond reads as the HALT encoding.
    function automatic logic [31:0] modelFetch(input logic [31:0] pc);
        if ((pc / 4) < 256) return m_mem[pc[9:2]];
        return 32'hFFFFFFFF;
    endfunction

    // Compare all four outputs against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"},   o_pc,          m_pc);
        checkOutput({tag, ".pc4"},  o_pc4,         m_pc + 32'd4);
        checkOutput({tag, ".inst"}, o_instruction, modelFetch(m_pc));
        checkOutput({tag, ".halt"}, {31'd0, o_halt}, {31'd0, m_halt});
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then check.
    task automatic applyStimulus(input bit step, input bit pcw,
                                 input bit br, input logic [31:0] ba,
                                 input bit jp, input logic [31:0] ja,
                                 input bit we, input logic [7:0] wa, input logic [31:0] wd,
                                 input string tag);
        logic [31:0] cur;
        i_step = step; i_pc_write = pcw;
        i_branch = br; i_branch_addr = ba;
        i_jump = jp;   i_jump_addr = ja;
        i_wr_en = we;  i_wr_addr = wa; i_wr_data = wd;
        cur = modelFetch(m_pc);
        if (step && pcw && !m_halt) begin
            if (cur == 32'hFFFFFFFF) m_halt = 1'b1;
            else if (jp)             m_pc = {ja[31:2], 2'b00};
            else if (br)             m_pc = {ba[31:2], 2'b00};
            else                     m_pc = m_pc + 32'd4;
        end
        if (we) m_mem[wa] = wd;
        @(posedge i_clk);
        #1;
        checkAll(tag);
    endtask

    task automatic stepCycle(input bit step, input bit pcw, input string tag);
        applyStimulus(step, pcw, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, tag);
    endtask

    task automatic loadWord(input logic [7:0] wa, input logic [31:0] wd);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, wa, wd, "load");
    endtask

    // Asynchronous reset mid-cycle; a load write attempted during reset must be dropped.
    task automatic doReset(input string tag);
        i_reset   = 1'b0;
        i_step    = 1'b1;
        i_pc_write = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_addr = 8'($urandom);
        i_wr_data = $urandom;
        #2;
        m_pc   = 32'd0;
        m_halt = 1'b0;
        checkAll(tag);
        @(posedge i_clk);
        #1;
        checkAll({tag, "_hold"});
        i_wr_en = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        i_reset = 1'b0; i_step = 1'b0; i_pc_write = 1'b0;
        i_branch = 1'b0; i_branch_addr = '0; i_jump = 1'b0; i_jump_addr = '0;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        m_pc = 32'd0; m_halt = 1'b0;

        #12;
        checkOutput("init.pc",   o_pc,  32'd0);
        checkOutput("init.pc4",  o_pc4, 32'd4);
        checkOutput("init.halt", {31'd0, o_halt}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Fill the whole memory with non-HALT words so every fetch is defined.
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            if (w == 32'hFFFFFFFF) w = 32'd0;
            loadWord(8'(a), w);
        end

        // Load the short program and run it until the HALT word.
        loadWord(8'd0, 32'h20010005);
        loadWord(8'd1, 32'h20020003);
        loadWord(8'd2, 32'h00221820);
        loadWord(8'd3, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) stepCycle(1'b1, 1'b1, "seq");
        checkOutput("seq.halt_pc",   o_pc,          32'd12);
        checkOutput("seq.halt_pc4",  o_pc4,         32'd16);
        checkOutput("seq.halt_inst", o_instruction, 32'hFFFFFFFF);
        checkOutput("seq.halt_flag", {31'd0, o_halt}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 8'd0, 32'd0, "halt_redirect");
        checkOutput("halt.pc_frozen", o_pc, 32'd12);

        // Stall at PC 4 for three cycles, then resume.
        doReset("rst1");
        checkOutput("rst1.mem0", o_instruction, 32'h20010005);
        stepCycle(1'b1, 1'b1, "pre_stall");
        for (int i = 0; i < 3; i++) begin
            stepCycle(1'b1, 1'b0, "stall");
            checkOutput("stall.pc",   o_pc,          32'd4);
            checkOutput("stall.inst", o_instruction, 32'h20020003);
        end
        stepCycle(1'b1, 1'b1, "resume");
        checkOutput("resume.pc", o_pc, 32'd8);

        // Reset at PC 8, memory contents survive, then write the word being fetched.
        doReset("rst2");
        checkOutput("rst2.pc",   o_pc,          32'd0);
        checkOutput("rst2.mem0", o_instruction, 32'h20010005);
        loadWord(8'd0, 32'h12345678);
        checkOutput("wr_fetch.inst", o_instruction, 32'h12345678);

        // Jump outranks branch; branch target low bits are masked.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 8'd0, 32'd0, "prio");
        checkOutput("prio.jump_pc", o_pc, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h23, 1'b0, 32'h0, 1'b0, 8'd0, 32'd0, "branch");
        checkOutput("branch.pc", o_pc, 32'h20);

        // Single-step: one enabled edge in every four.
        for (int i = 0; i < 12; i++) stepCycle((i % 4) == 0, 1'b1, "single_step");
        checkOutput("single_step.pc", o_pc, 32'h2C);

        // Jump past the end of memory, then halt on the next step.
        doReset("rst3");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0, 8'd0, 32'd0, "oor");
        checkOutput("oor.inst", o_instruction, 32'hFFFFFFFF);
        stepCycle(1'b1, 1'b1, "oor_step");
        checkOutput("oor.halt", {31'd0, o_halt}, 32'd1);
        checkOutput("oor.pc",   o_pc, 32'h400);

        // Top of address space: PC+4 wraps to zero.
        doReset("rst4");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 8'd0, 32'd0, "wrap");
        checkOutput("wrap.pc",  o_pc,  32'hFFFFFFFC);
        checkOutput("wrap.pc4", o_pc4, 32'd0);

        // Random traffic with occasional resets and HALT words.
        doReset("rst5");
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ja, ba, wd;
            if ($urandom_range(0, 39) == 0) begin
                doReset("rnd_rst");
            end else begin
                ja = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
                ba = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
                wd = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFF : $urandom;
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                              $urandom_range(0, 5) == 0, ba,
                              $urandom_range(0, 7) == 0, ja,
                              $urandom_range(0, 9) == 0, 8'($urandom), wd, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
